pll_reset_sequencer: RTL and testbench

Drives the system PLL's reset input and consumes its asynchronous `locked` output. It waits for a stable lock, then releases a set of downstream active-low resets in a fixed staged order. On loss of lock, timeout or software request it re-asserts every downstream reset and re-initialises the PLL. It runs on the free-running 50 MHz board reference clock, never on a PLL output.

---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/bit_synchronizer.sv | 29 ++
 rtl/pll_reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } seq_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : unsigned'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous status inputs; flops clear to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification and staged release of downstream active-low resets.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter int unsigned NUM_RESETS       = 3,
  parameter int unsigned STAGE_GAP        = 8,
  parameter int unsigned CNT_W            = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] rst_out_n,
  output logic                  ready,
  output logic [CNT_W-1:0]      lock_loss_count,
  output logic                  timeout_err
);

  localparam int unsigned CW = cnt_width(max2(max2(RST_PULSE_CYCLES, STABLE_CYCLES),
                                              max2(TIMEOUT_CYCLES, STAGE_GAP)));
  localparam int unsigned IW = cnt_width(NUM_RESETS - 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_RESETS - 1);

  logic locked_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]      llc_q, llc_d;
  logic                  terr_q, terr_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    llc_d     = llc_q;
    terr_d    = terr_q;
    lock_lost = 1'b0;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          // A single downstream reset is already the last one: skip straight to RUN.
          state_d = (LAST_IDX == '0) ? RUN : RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          lock_lost = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          if (idx_d == LAST_IDX) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          lock_lost = 1'b1;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Software request outranks a same-cycle lock loss and is never counted.
    if (sw_reset_req) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (lock_lost) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      idx_d   = '0;
      if (llc_q != '1) begin
        llc_d = llc_q + CNT_W'(1);
      end
    end

    // Outputs are decoded from the next state so they register alongside it.
    pll_rst_d = (state_d == PLL_RST);
    ready_d   = (state_d == RUN);
    for (int unsigned i = 0; i < NUM_RESETS; i++) begin
      rst_out_d[i] = (state_d == RUN) || ((state_d == RELEASE) && (IW'(i) <= idx_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      llc_q     <= '0;
      terr_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      llc_q     <= llc_d;
      terr_q    <= terr_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign rst_out_n       = rst_out_q;
  assign ready           = ready_q;
  assign lock_loss_count = llc_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots per cycle, a monitor compares them.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       pll_rst;
  logic [2:0] rst_out_n;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic       timeout_err;

  pll_reset_sequencer #(
    .SYNC_STAGES      (2),
    .RST_PULSE_CYCLES (4),
    .STABLE_CYCLES    (8),
    .TIMEOUT_CYCLES   (64),
    .NUM_RESETS       (3),
    .STAGE_GAP        (2),
    .CNT_W            (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .sw_reset_req    (sw_reset_req),
    .pll_rst         (pll_rst),
    .rst_out_n       (rst_out_n),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {timeout_err, lock_loss_count[7:0], ready, rst_out_n[2:0], pll_rst}
  localparam logic [13:0] M_PLL  = 14'h0001;
  localparam logic [13:0] M_RST  = 14'h000E;
  localparam logic [13:0] M_LLC  = 14'h1FE0;
  localparam logic [13:0] M_TERR = 14'h2000;
  localparam logic [13:0] M_ALL  = 14'h3FFF;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [13:0] val;
    logic [13:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [13:0] act;
  assign act = {timeout_err, lock_loss_count, ready, rst_out_n, pll_rst};

  function automatic logic [13:0] snap(logic terr, logic [7:0] llc, logic rdy,
                                       logic [2:0] rst, logic pll);
    return {terr, llc, rdy, rst, pll};
  endfunction

  function automatic void expect_at(int unsigned at, string name, logic [13:0] val,
                                    logic [13:0] mask);
    exp_t        e;
    int unsigned pos;
    e.cyc  = at;
    e.name = name;
    e.val  = val;
    e.mask = mask;
    pos = sb_q.size();
    while (pos > 0 && sb_q[pos-1].cyc > at) pos--;
    sb_q.insert(pos, e);
  endfunction

  // Release staircase when pll_locked is driven high at cycle l and WAIT_LOCK is already active.
  function automatic void expect_release(int unsigned l, logic [7:0] llc, int unsigned upto);
    logic [2:0] rst_tab [7];
    logic       rdy_tab [7];
    rst_tab = '{3'b000, 3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111};
    rdy_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int unsigned k = 0; k < 7; k++) begin
      if (10 + k <= upto)
        expect_at(l + 10 + k, "release_step", snap(1'b0, llc, rdy_tab[k], rst_tab[k], 1'b0), M_ALL);
    end
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s slot missed: checked at cyc=%0d, required cyc=%0d", e.name, cyc, e.cyc);
      end else if (((act ^ e.val) & e.mask) != '0) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h required=%h mask=%h", e.name, cyc, act, e.val, e.mask);
      end
    end
  end

  task automatic tick(int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0, l, d, t, g, r;
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;

    tick(3);
    expect_at(cyc + 1, "reset_state", snap(1'b0, 8'd0, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(2);

    // Clean bring-up
    c0 = cyc;
    reset_n = 1'b1;
    expect_at(c0 + 3, "pll_rst_pulse_hi", snap(1'b0, 8'd0, 1'b0, 3'b000, 1'b1), M_ALL);
    expect_at(c0 + 4, "pll_rst_pulse_lo", snap(1'b0, 8'd0, 1'b0, 3'b000, 1'b0), M_ALL);
    tick(10);
    l = cyc;
    pll_locked = 1'b1;
    expect_release(l, 8'd0, 16);
    tick(20);

    // Lock loss in RUN, then re-run up to the 011 stage
    d = cyc;
    pll_locked = 1'b0;
    expect_at(d + 2, "loss_before", snap(1'b0, 8'd0, 1'b1, 3'b111, 1'b0), M_ALL);
    expect_at(d + 3, "loss_resp", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    expect_at(d + 6, "loss_pll_hi", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_PLL | M_RST);
    expect_at(d + 7, "loss_pll_lo", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_PLL | M_RST);
    tick(10);
    l = cyc;
    pll_locked = 1'b1;
    expect_release(l, 8'd1, 13);
    tick(13);

    // Software request while rst_out_n = 011
    sw_reset_req = 1'b1;
    expect_at(l + 14, "sw_in_release", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(1);
    sw_reset_req = 1'b0;
    expect_at(l + 17, "sw_pll_hi", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_PLL | M_RST);
    expect_at(l + 18, "sw_pll_lo", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_PLL | M_RST);
    expect_at(l + 26, "relock_hold", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    expect_at(l + 27, "relock_bit0", snap(1'b0, 8'd1, 1'b0, 3'b001, 1'b0), M_ALL);
    expect_at(l + 31, "relock_ready", snap(1'b0, 8'd1, 1'b1, 3'b111, 1'b0), M_ALL);
    tick(21);

    // Software request coinciding with the first locked_s=0 cycle
    d = cyc;
    pll_locked = 1'b0;
    expect_at(d + 2, "simul_before", snap(1'b0, 8'd1, 1'b1, 3'b111, 1'b0), M_ALL);
    tick(2);
    sw_reset_req = 1'b1;
    expect_at(d + 3, "simul_resp", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(1);
    sw_reset_req = 1'b0;
    expect_at(d + 6, "simul_llc", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(7);

    // Glitchy lock: 5 cycles high, 3 low, then steady
    g = cyc;
    pll_locked = 1'b1;
    expect_at(g + 7, "glitch_no_rel_a", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    expect_at(g + 9, "glitch_no_rel_b", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    tick(5);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    expect_release(g + 8, 8'd1, 16);
    tick(20);

    // Timeout with lock held low
    t = cyc;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b1;
    expect_at(t + 1, "to_enter", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(1);
    sw_reset_req = 1'b0;
    expect_at(t + 4,   "to_pll_hi",   snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b1), M_PLL | M_RST | M_TERR);
    expect_at(t + 5,   "to_pll_lo",   snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_PLL | M_RST | M_TERR);
    expect_at(t + 68,  "to_last_wait", snap(1'b0, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    expect_at(t + 69,  "to_fire",     snap(1'b1, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    expect_at(t + 72,  "to_repulse",  snap(1'b1, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    expect_at(t + 73,  "to_rewait",   snap(1'b1, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    expect_at(t + 136, "to_sticky",   snap(1'b1, 8'd1, 1'b0, 3'b000, 1'b0), M_ALL);
    expect_at(t + 137, "to_period",   snap(1'b1, 8'd1, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(149);

    // Mid-sequence block reset clears sticky and counter
    r = cyc;
    reset_n = 1'b0;
    expect_at(r + 1, "midreset", snap(1'b0, 8'd0, 1'b0, 3'b000, 1'b1), M_ALL);
    tick(2);
    reset_n = 1'b1;
    tick(4);

    // Saturation: 260 losses taken in RELEASE
    for (int unsigned i = 1; i <= 260; i++) begin
      l = cyc;
      pll_locked = 1'b1;
      expect_at(l + 15, "sat_llc",
                snap(1'b0, (i > 255) ? 8'd255 : 8'(i), 1'b0, 3'b000, 1'b1), M_ALL);
      tick(12);
      pll_locked = 1'b0;
      tick(8);
    end
    expect_at(cyc + 2, "sat_hold", snap(1'b0, 8'd255, 1'b0, 3'b000, 1'b0), M_LLC | M_RST);
    tick(5);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
